// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction constants,
// field widths and the IF/ID pipeline bundle.
package cpu_defs;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 6;
  localparam int JIDX_W   = 26;

  localparam logic [XLEN-1:0]     NOP_INST = 32'h0000_0000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] jump_addr(
    input logic [XLEN-1:0]   pc4,
    input logic [JIDX_W-1:0] idx
  );
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter with next-PC selection.
// Redirects win over stall; wrap is modulo 2^32.
module pc_reg
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] next_pc;
  logic            load;

  // Next-PC mux, oldest redirect first.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    load     = 1'b1;
    priority case (1'b1)
      branch_taken: next_pc = branch_target;
      jump:         next_pc = jump_target;
      stall:        load    = 1'b0;
      default:      next_pc = pc_plus4;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, IF/ID register
// and sticky fetch-fault flag.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  output logic [XLEN-1:0]   if_id_inst,
  output logic [XLEN-1:0]   if_id_pc4,
  output logic              if_id_valid,
  output logic              fetch_fault
);

  if_id_t          if_id_q;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] fetch_word;
  logic            fetch_ok;
  logic            bubble;
  logic            load;
  logic            fault;

  assign jump_target = jump_addr(if_id_q.pc4, jump_index);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
  );

  // Range/alignment check and IF/ID control.
  always_comb begin
    fetch_ok   = (pc < 32'(IMEM_BYTES))
               && (pc[1:0] == 2'b00);
    fetch_word = fetch_ok ? imem_data : NOP_INST;
    bubble     = branch_taken | jump | flush;
    load       = !bubble && !stall;
  end

  // IF/ID register: bubble, hold or load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= '{NOP_INST, '0, 1'b0};
    end else if (bubble) begin
      if_id_q <= '{NOP_INST, '0, 1'b0};
    end else if (load) begin
      if_id_q <= '{fetch_word, pc_plus4, fetch_ok};
    end
  end

  // Sticky fault on any real load of a bad PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (load && !fetch_ok) begin
      fault <= 1'b1;
    end
  end

  assign imem_addr   = pc;
  assign if_id_inst  = if_id_q.inst;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
  assign fetch_fault = fault;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter, drives the address port of the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for the decode stage. It applies redirects (branch resolved in EX, jump decoded in ID), stalls from the hazard unit, and bubble insertion. It also flags fetches outside the implemented memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_BYTES`, 256, implemented instruction-memory size in bytes. Power of two, at least 4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush`  in  1  external request to load a bubble into IF/ID.
- `branch_taken`  in  1  EX stage: branch resolved taken.
- `branch_target`  in  32  EX stage: byte address of the branch target.
- `jump`  in  1  ID stage: J-type instruction decoded.
- `jump_index`  in  26  ID stage: instr[25:0] of the jump.
- `imem_addr`  out  32  byte address to instruction memory; equals the PC.
- `imem_data`  in  32  instruction word from memory (big-endian, combinational).
- `if_id_inst`  out  32  registered instruction for ID.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_fault`  out  1  sticky: an out-of-range or misaligned PC was fetched.

## Operation
- Internal state: `pc` (32), the IF/ID register (inst, pc4, valid), and `fault` (1). `imem_addr` = `pc`, combinationally.
- `pc_plus4` = `pc` + 4, modulo 2^32.
- Jump target = {`if_id_pc4`[31:28], `jump_index`, 2'b00}.
- Next-PC priority, highest first:
  1. `branch_taken` → `branch_target`.
  2. `jump` → jump target.
  3. `stall` → `pc` (hold).
  4. Otherwise → `pc_plus4`.
- A redirect overrides `stall`, because the branch or jump is older than the stalled instruction.
- IF/ID update, same priority:
  - `branch_taken`, `jump` or `flush` → bubble: inst = `NOP_INST` (32'h0), pc4 = 0, valid = 0.
  - Else `stall` → hold.
  - Else load {`fetch_word`, `pc_plus4`, `fetch_ok`}.
- `fetch_ok` = (`pc` < `IMEM_BYTES`) && (`pc`[1:0] == 0).
  - `fetch_word` = `imem_data` when `fetch_ok`, else `NOP_INST`.
- `fault` sets on any clock edge where `fetch_ok` = 0 and IF/ID is loading (not held, not bubbled). It clears only on reset. `fetch_fault` = `fault`.
- `flush` together with `stall` and no redirect: PC holds and IF/ID takes a bubble.

## Timing
- Reset (async, immediate on `rst_n` low):
  - `pc` = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `if_id_inst` = 0, `if_id_pc4` = 0, `if_id_valid` = 0, `fetch_fault` = 0.
- First fetch happens in the first cycle after `rst_n` rises. That word reaches IF/ID at the next rising edge.
- Fetch latency: the word at PC p appears on `if_id_inst` one cycle after `imem_addr` = p.
- Redirect: the target appears on `imem_addr` the cycle after `branch_taken`/`jump` is sampled high. One bubble enters IF/ID.
- Stall: `imem_addr` and IF/ID are unchanged for exactly as many cycles as `stall` is high.
- PC wrap: 32'hFFFF_FFFC + 4 = 0. No error is raised for the wrap itself; the out-of-range check applies as normal.

## Structure
- Shared package `cpu_defs`: `NOP_INST` (32'h0), opcode constants (`OP_J` 6'b000010, `OP_BEQ` 6'b000100), instruction field widths.
- One sub-module, `pc_reg`: the PC register with reset value, load enable and next-PC mux.
- The IF/ID register and fault logic live in `inst_fetch`.

## Test plan
- Reset and sequential fetch: hold `rst_n` low, then release → `imem_addr` 0 then 4. On the next edge `if_id_inst` = 32'h8FE1_0001, `if_id_pc4` = 4, `if_id_valid` = 1.
- Stall: assert `stall` for 2 cycles at PC 12 → `imem_addr` stays 12 and IF/ID stays unchanged. After release, `imem_addr` = 16.
- Jump: `jump` = 1, `jump_index` = 3, `if_id_pc4` = 28 → next `imem_addr` = 12. IF/ID becomes bubble (inst 0, valid 0). The following edge loads the word at 12.
- Simultaneous events: `branch_taken` (target 28), `jump` and `stall` all high → `imem_addr` = 28 and IF/ID takes a bubble. Separately, `flush` with `stall` → PC holds and IF/ID takes a bubble.
- Fault: `branch_target` = 256 with `IMEM_BYTES` = 256 → the fetched entry is inst 0, valid 0, and `fetch_fault` = 1 on that edge. It stays 1 after a later valid branch to 0, until `rst_n` goes low. Repeat with target 6 (misaligned) → same result.
- Mid-run reset: drop `rst_n` asynchronously between edges while PC = 20 → all outputs take their reset values immediately, without waiting for a clock edge.
